// File: rtl/cfu_cmd_issuer.sv
// CFU command issuer: buffers custom-instruction requests in a small FIFO, issues each
// one to the CFU as a single-cycle strobe, waits for the result or a timeout and returns
// it on a valid/ready response port. At most one command is outstanding at the CFU.
module cfu_cmd_issuer #(
  parameter int unsigned INT32_SIZE     = 32,
  parameter int unsigned CMD_WIDTH      = 7,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CMD_WIDTH-1:0]  req_cmd,
  input  logic [INT32_SIZE-1:0] req_op0,
  input  logic [INT32_SIZE-1:0] req_op1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [INT32_SIZE-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic                  cfu_en,
  output logic [CMD_WIDTH-1:0]  cfu_cmd,
  output logic [INT32_SIZE-1:0] cfu_inp0,
  output logic [INT32_SIZE-1:0] cfu_inp1,
  input  logic [INT32_SIZE-1:0] cfu_ret,
  input  logic                  cfu_valid,
  output logic                  busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e r_state, w_state_d;

  logic [CMD_WIDTH-1:0]  r_fifo_cmd [FIFO_DEPTH];
  logic [INT32_SIZE-1:0] r_fifo_op0 [FIFO_DEPTH];
  logic [INT32_SIZE-1:0] r_fifo_op1 [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]       r_count;
  logic [TmrW-1:0]       r_timer;
  logic [CMD_WIDTH-1:0]  r_cfu_cmd;
  logic [INT32_SIZE-1:0] r_cfu_inp0, r_cfu_inp1;
  logic [INT32_SIZE-1:0] r_rsp_data;
  logic                  r_rsp_timeout;

  logic w_push, w_pop, w_nonempty, w_capture, w_abort;

  assign w_nonempty  = (r_count != '0);
  assign req_ready   = (r_count != CntFull);
  assign w_push      = req_valid & req_ready;
  assign cfu_en      = (r_state == StIssue);
  assign rsp_valid   = (r_state == StResp);
  assign busy        = (r_state != StIdle) | w_nonempty;
  assign cfu_cmd     = r_cfu_cmd;
  assign cfu_inp0    = r_cfu_inp0;
  assign cfu_inp1    = r_cfu_inp1;
  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;

  // Next-state and pop/capture decode; cfu_valid is only looked at in WAIT.
  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_nonempty) begin
          w_pop     = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: w_state_d = StWait;
      StWait: begin
        // A result on the final WAIT cycle beats the timeout.
        if (cfu_valid) begin
          w_capture = 1'b1;
          w_state_d = StResp;
        end else if (r_timer == TmrLast) begin
          w_abort   = 1'b1;
          w_state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          if (w_nonempty) begin
            w_pop     = 1'b1;
            w_state_d = StIssue;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // FIFO payload storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_cmd[r_wr_ptr] <= req_cmd;
      r_fifo_op0[r_wr_ptr] <= req_op0;
      r_fifo_op1[r_wr_ptr] <= req_op1;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

  // CFU operand registers: loaded on pop, held from ISSUE through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfu_cmd  <= '0;
      r_cfu_inp0 <= '0;
      r_cfu_inp1 <= '0;
    end else if (w_pop) begin
      r_cfu_cmd  <= r_fifo_cmd[r_rd_ptr];
      r_cfu_inp0 <= r_fifo_op0[r_rd_ptr];
      r_cfu_inp1 <= r_fifo_op1[r_rd_ptr];
    end
  end

  // WAIT-cycle counter: cleared in ISSUE, stops at TmrLast so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (r_state == StIssue) begin
      r_timer <= '0;
    end else if ((r_state == StWait) && !w_capture && !w_abort) begin
      r_timer <= r_timer + TmrW'(1);
    end
  end

  // Response registers: written only when leaving WAIT, stable throughout RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
    end else if (w_capture) begin
      r_rsp_data    <= cfu_ret;
      r_rsp_timeout <= 1'b0;
    end else if (w_abort) begin
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// Bench for cfu_cmd_issuer: a CFU model answers each issued command according to a
// per-request plan (latency, result); expected issues and responses are queued when a
// request is accepted and popped by independent monitors.
module tb_cfu_cmd_issuer;

  localparam int TO = 8;

  typedef struct {logic [6:0] cmd; logic [31:0] op0; logic [31:0] op1;} iss_t;
  typedef struct {int lat; logic [31:0] ret;} plan_t;
  typedef struct {logic [31:0] data; logic to;} rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [6:0]  req_cmd;
  logic [31:0] req_op0, req_op1;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        cfu_en;
  logic [6:0]  cfu_cmd;
  logic [31:0] cfu_inp0, cfu_inp1;
  logic [31:0] cfu_ret = '0;
  logic        cfu_valid = 1'b0;
  logic        busy;

  cfu_cmd_issuer #(
    .INT32_SIZE(32), .CMD_WIDTH(7), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .cfu_en(cfu_en), .cfu_cmd(cfu_cmd), .cfu_inp0(cfu_inp0), .cfu_inp1(cfu_inp1),
    .cfu_ret(cfu_ret), .cfu_valid(cfu_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  iss_t  iss_q[$];
  plan_t plan_q[$];
  rsp_t  rsp_q[$];

  int rsp_mode = 1;      // 0: hold rsp_ready low, 1: high, 2: random
  int en_count = 0;
  int en_cyc = 0;
  int rsp_count = 0;
  int rsp_acc_cyc = 0;
  logic [6:0] last_cmd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CFU model: answers per plan, then leaves cfu_valid high with changing garbage.
  initial begin
    int    wi;
    bit    active;
    bit    prev_en;
    plan_t cur;
    iss_t  ie;
    active = 0; prev_en = 0; wi = 0; cur.lat = 0; cur.ret = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0; prev_en = 0; cfu_valid = 1'b0;
      end else begin
        if (cfu_en) begin
          en_count++;
          en_cyc = cyc;
          last_cmd = cfu_cmd;
          if (prev_en) chk("cfu_en_single_cycle", 32'(prev_en), 32'(0));
          if (iss_q.size() == 0) begin
            chk("issue_unexpected", 32'(iss_q.size()), 32'(1));
          end else begin
            ie = iss_q.pop_front();
            chk("issue_cmd", 32'(cfu_cmd), 32'(ie.cmd));
            chk("issue_op0", cfu_inp0, ie.op0);
            chk("issue_op1", cfu_inp1, ie.op1);
          end
          if (plan_q.size() != 0) cur = plan_q.pop_front();
          else cur.lat = 1 << 30;
          active = 1;
          wi = 0;
        end else if (active) begin
          if (wi == cur.lat) begin
            cfu_valid = 1'b1;
            cfu_ret   = cur.ret;
            active    = 0;
          end else begin
            cfu_valid = 1'b0;
            cfu_ret   = $urandom;
          end
          wi++;
        end else if (cfu_valid) begin
          cfu_ret = $urandom;
        end
        prev_en = cfu_en;
      end
    end
  end

  // Response monitor: drives rsp_ready, checks hold-stability and scoreboard order.
  initial begin
    bit          prev_hold;
    logic [31:0] prev_data;
    logic        prev_to;
    rsp_t        e;
    prev_hold = 0; prev_data = '0; prev_to = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 0;
      end else begin
        case (rsp_mode)
          0:       rsp_ready = 1'b0;
          1:       rsp_ready = 1'b1;
          default: rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (prev_hold) begin
          chk("rsp_valid_held", 32'(rsp_valid), 32'(1));
          chk("rsp_data_held", rsp_data, prev_data);
          chk("rsp_timeout_held", 32'(rsp_timeout), 32'(prev_to));
        end
        if (rsp_valid) begin
          chk("cfu_cmd_stable_in_resp", 32'(cfu_cmd), 32'(last_cmd));
          if (rsp_ready) begin
            if (rsp_q.size() == 0) begin
              chk("rsp_unexpected", 32'(rsp_q.size()), 32'(1));
            end else begin
              e = rsp_q.pop_front();
              chk("rsp_data", rsp_data, e.data);
              chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            end
            rsp_count++;
            rsp_acc_cyc = cyc;
            prev_hold = 0;
          end else begin
            prev_hold = 1;
            prev_data = rsp_data;
            prev_to   = rsp_timeout;
          end
        end else begin
          prev_hold = 0;
        end
      end
    end
  end

  // Present one request and wait (bounded) for acceptance; queues its expectations.
  task automatic send(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                      input int lat, input logic [31:0] ret);
    int    t;
    iss_t  ie;
    plan_t pe;
    rsp_t  re;
    t = 0;
    req_valid = 1'b1; req_cmd = c; req_op0 = a; req_op1 = b;
    while (!req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("send_accept_timeout", 32'(req_ready), 32'(1));
    end else begin
      ie.cmd = c; ie.op0 = a; ie.op1 = b;
      pe.lat = lat; pe.ret = ret;
      re.to = (lat >= TO);
      re.data = re.to ? 32'h0 : ret;
      iss_q.push_back(ie);
      plan_q.push_back(pe);
      rsp_q.push_back(re);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, output int c);
    int t;
    t = 0;
    while (!rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) chk({name, "_rsp_seen"}, 32'(rsp_valid), 32'(1));
    c = cyc;
  endtask

  task automatic wait_en(input string name, output int c);
    int t;
    t = 0;
    while (!cfu_en && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cfu_en) chk({name, "_en_seen"}, 32'(cfu_en), 32'(1));
    c = cyc;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drained"}, 32'(rsp_q.size()), 32'(0));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_req_ready"}, 32'(req_ready), 32'(1));
    chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({name, "_rsp_data"}, rsp_data, 32'h0);
    chk({name, "_rsp_timeout"}, 32'(rsp_timeout), 32'(0));
    chk({name, "_cfu_en"}, 32'(cfu_en), 32'(0));
    chk({name, "_cfu_cmd"}, 32'(cfu_cmd), 32'(0));
    chk({name, "_cfu_inp0"}, cfu_inp0, 32'h0);
    chk({name, "_cfu_inp1"}, cfu_inp1, 32'h0);
    chk({name, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int c0, c1, n0, r0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_cmd = '0; req_op0 = '0; req_op1 = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Single op: result on the first WAIT cycle, response three edges after accept.
    rsp_mode = 1;
    n0 = en_count;
    send(7'h05, 32'd3, 32'd4, 0, 32'h1234);
    c0 = cyc;
    wait_rsp("single", c1);
    chk("single_latency", 32'(c1 - c0), 32'd3);
    drain("single");
    chk("single_en_pulses", 32'(en_count - n0), 32'd1);

    // FIFO fill with the response port stalled.
    rsp_mode = 0;
    n0 = en_count;
    for (int i = 0; i < 5; i++) send(7'(8'h10 + i), 32'(i), 32'(100 + i), 0, 32'(16'hA000 + i));
    chk("fill_ready_low_after_5", 32'(req_ready), 32'(0));
    chk("fill_one_popped", 32'(en_count - n0), 32'd1);
    req_valid = 1'b1; req_cmd = 7'h15; req_op0 = 32'd5; req_op1 = 32'd105;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fill_6th_stalls", 32'(req_ready), 32'(0));
    end
    rsp_mode = 1;
    send(7'h15, 32'd5, 32'd105, 0, 32'hA005);
    drain("fill");
    chk("fill_en_pulses", 32'(en_count - n0), 32'd6);

    // Timeout: WAIT lasts TO cycles, response on the following edge.
    send(7'h21, 32'h11, 32'h22, 1000, 32'hDEAD);
    wait_en("timeout", c0);
    wait_rsp("timeout", c1);
    chk("timeout_wait_len", 32'(c1 - c0), 32'(TO + 1));
    drain("timeout");

    // Result arriving on the final WAIT cycle wins over the timeout.
    send(7'h22, 32'h33, 32'h44, TO - 1, 32'hBEEF);
    wait_en("race", c0);
    wait_rsp("race", c1);
    chk("race_wait_len", 32'(c1 - c0), 32'(TO + 1));
    drain("race");

    // Backpressure: response held 10 cycles with another request queued.
    rsp_mode = 0;
    send(7'h31, 32'h1, 32'h2, 0, 32'h5151);
    send(7'h32, 32'h3, 32'h4, 1, 32'h5252);
    wait_rsp("bp", c1);
    n0 = en_count;
    repeat (10) @(negedge clk);
    chk("bp_no_new_en", 32'(en_count - n0), 32'd0);
    chk("bp_still_valid", 32'(rsp_valid), 32'(1));
    rsp_mode = 1;
    wait_en("bp", c0);
    chk("bp_pop_on_accept_edge", 32'(c0), 32'(rsp_acc_cyc + 1));
    drain("bp");

    // Reset in WAIT with two requests queued.
    send(7'h41, 32'hAAAA, 32'hBBBB, 1000, 32'h1);
    send(7'h42, 32'hCCCC, 32'hDDDD, 1000, 32'h2);
    send(7'h43, 32'hEEEE, 32'hFFFF, 1000, 32'h3);
    repeat (2) @(negedge clk);
    chk("rst_busy_before", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    iss_q.delete();
    plan_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'(0));
    chk("post_rst_req_ready", 32'(req_ready), 32'(1));
    n0 = en_count;
    r0 = rsp_count;
    repeat (20) @(negedge clk);
    chk("post_rst_no_issue", 32'(en_count - n0), 32'd0);
    chk("post_rst_no_rsp", 32'(rsp_count - r0), 32'd0);

    // Randomised traffic with random response backpressure.
    rsp_mode = 2;
    r0 = rsp_count;
    for (int i = 0; i < 40; i++) begin
      int sel, lat;
      sel = $urandom_range(0, 9);
      if (sel < 6)       lat = $urandom_range(0, 3);
      else if (sel == 6) lat = TO - 1;
      else if (sel == 7) lat = TO;
      else               lat = 1000;
      send(7'($urandom_range(0, 127)), $urandom, $urandom, lat, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("random");
    chk("random_rsp_count", 32'(rsp_count - r0), 32'd40);
    chk("random_iss_q_empty", 32'(iss_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
